apple1_pia: RTL
===============

// Module: apple1_pia
//
// PURPOSE
// Apple-1 6821-style PIA register file at 0xD010-0xD013 between CPU bus and character I/O.
// Upstream: takes key bytes from a keyboard/UART source via valid/ready.
// Downstream: buffers CPU display writes in a FIFO drained by the VGA/UART sink via valid/ready.
// Reports KBDCR key-strobe and DSP busy (bit 7) exactly as WozMon/BASIC poll them.
//
// PARAMETERS
// FIFO_AW   4   log2 of display FIFO depth (default 16 entries)
//
// PORTS
// clk25      in   1  25 MHz master clock
// rst        in   1  reset, asynchronous, active-high
// enable     in   1  CPU clock enable; bus side effects only when high
// cs         in   1  chip select (0xD010-0xD013 decode)
// address    in   2  register select: 0 KBD, 1 KBDCR, 2 DSP, 3 DSPCR
// w_en       in   1  CPU write strobe
// din        in   8  CPU write data
// dout       out  8  CPU read data (combinational from registers)
// kbd_data   in   8  key byte from source
// kbd_valid  in   1  key byte valid
// kbd_ready  out  1  block accepts a key (= !key_pending)
// dsp_data   out  7  FIFO head character
// dsp_valid  out  1  FIFO not empty
// dsp_ready  in   1  sink consumes head when dsp_valid & dsp_ready
//
// BEHAVIOUR
// - Reset: key_pending=0, key_reg=0, kbdcr=0, dspcr=0, last_dsp=0, overflow=0, FIFO empty;
//   kbd_ready=1, dsp_valid=0, dsp_data=0, dout reflects these reset registers.
// - bus_rd = cs & enable & !w_en; bus_wr = cs & enable & w_en.
// - Key capture: kbd_valid & kbd_ready -> key_reg <= kbd_data[6:0], except 0x61-0x7A
//   are stored minus 0x20 (uppercase only); key_pending <= 1. One-cycle latency to KBDCR bit7.
// - Read addr0 (KBD): dout={1'b1,key_reg}; bus_rd clears key_pending next edge.
// - Read addr1 (KBDCR): dout={key_pending,kbdcr[6:0]}; no side effect.
// - Read addr2 (DSP): dout={fifo_full,last_dsp}; bit7=1 means busy.
// - Read addr3 (DSPCR): dout={1'b0,overflow,dspcr[5:0]}.
// - Write addr0: ignored. Write addr1: kbdcr[6:0]<=din[6:0] (bit7 read-only strobe).
// - Write addr3: dspcr[5:0]<=din[5:0]; clears overflow.
// - Write addr2: last_dsp<=din[6:0]; push din[6:0] if FIFO not full or a pop occurs the same edge;
//   otherwise drop the byte and set overflow (sticky).
// - FIFO: wr/rd pointers FIFO_AW bits, wrap modulo 2**FIFO_AW; count FIFO_AW+1 bits.
//   full = count==2**FIFO_AW; empty = count==0. Push only: count+1. Pop only: count-1.
//   Push+pop: count unchanged.
// - dsp_data = mem[rd_ptr] (first-word-fall-through); pop when dsp_valid & dsp_ready.
//   dsp_ready while empty: no effect.
// - Push to empty FIFO: dsp_valid rises on the next edge (one-cycle latency).
// - No side effects when enable=0 or cs=0, even if w_en is high.
// - Reset mid-operation: FIFO contents discarded and pending key lost; sink sees dsp_valid drop
//   asynchronously.
//
// TESTING
// - Reset -> dout@1=0x00, kbd_ready=1, dsp_valid=0; read addr2 -> 0x00.
// - kbd_data=0x61 pulse -> kbd_ready=0, KBDCR=0x80, KBD read=0xC1.
//   After the KBD read: KBDCR=0x00, kbd_ready=1.
// - Write 0x8D to addr2 with dsp_ready=0 -> dsp_valid=1, dsp_data=0x0D; read addr2=0x0D.
//   Raise dsp_ready -> one pop, dsp_valid=0.
// - 16 writes (0x41..0x50), dsp_ready=0 -> read addr2 bit7=1.
//   17th write dropped -> DSPCR bit6=1; drain yields 0x41..0x50 in order.
// - Full FIFO with a write and dsp_ready=1 on the same enable cycle -> count stays 16,
//   no overflow, new byte last out.
// - Write to addr2 with enable=0, or key read with cs=0 -> no FIFO change, key_pending unchanged.

Source files
------------

// File: rtl/apple1_pia_if.sv
// apple1_pia_if: groups the CPU bus, the keyboard source handshake and the
// display sink handshake of the Apple-1 PIA.
//
// Handshake rule (both streams): a byte moves on a clk25 rising edge where
// valid and ready are both high. The source holds data stable while valid is
// high and ready is low. A sink may raise ready while valid is low; that has
// no effect.
//
//   enable, cs, address[1:0], w_en, din[7:0]  CPU bus into the PIA
//   dout[7:0]                                 CPU read data out of the PIA
//   kbd_data[7:0], kbd_valid / kbd_ready      key source -> PIA
//   dsp_data[6:0], dsp_valid / dsp_ready      PIA -> display sink
//
// slave  : the view used by the PIA itself
// master : the view used by whatever drives the PIA (CPU, source, sink)
interface apple1_pia_if;
    logic       enable;
    logic       cs;
    logic [1:0] address;
    logic       w_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       kbd_ready;
    logic [6:0] dsp_data;
    logic       dsp_valid;
    logic       dsp_ready;

    modport slave (
        input  enable, cs, address, w_en, din, kbd_data, kbd_valid, dsp_ready,
        output dout, kbd_ready, dsp_data, dsp_valid
    );

    modport master (
        output enable, cs, address, w_en, din, kbd_data, kbd_valid, dsp_ready,
        input  dout, kbd_ready, dsp_data, dsp_valid
    );
endinterface

// File: rtl/apple1_pia.sv
// apple1_pia: 6821-style PIA register file for the Apple-1 at 0xD010-0xD013.
// It sits between the CPU bus and character I/O. Key bytes arrive from a
// keyboard/UART source and are latched into KBD with a strobe in KBDCR bit 7.
// Display bytes written to DSP are queued in a first-word-fall-through FIFO.
// That FIFO is drained by a VGA/UART sink. DSP bit 7 reads as busy while the
// FIFO is full.
//
// Ports
//   clk25  25 MHz master clock
//   rst    asynchronous, active-high reset
//   bus    apple1_pia_if.slave
//            CPU bus:     enable, cs, address, w_en, din, dout
//            key source:  kbd_data, kbd_valid, kbd_ready
//            display:     dsp_data, dsp_valid, dsp_ready
//
// Registers: 0 KBD, 1 KBDCR, 2 DSP, 3 DSPCR.
module apple1_pia #(
    parameter int FIFO_AW = 4
) (
    input  logic        clk25,
    input  logic        rst,
    apple1_pia_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    logic             key_pending;
    logic [6:0]       key_reg;
    logic [6:0]       kbdcr;
    logic [5:0]       dspcr;
    logic [6:0]       last_dsp;
    logic             overflow;

    logic [6:0]       mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    logic bus_rd, bus_wr;
    logic fifo_full, fifo_empty;
    logic capture, kbd_read;
    logic dsp_wr, push, pop;
    logic [6:0] key_in, key_upper;

    // Bit 7 of a key byte and of CPU write data is never stored.
    logic unused_bits;
    assign unused_bits = ^{bus.kbd_data[7], bus.din[7]};

    assign bus_rd = bus.cs & bus.enable & ~bus.w_en;
    assign bus_wr = bus.cs & bus.enable &  bus.w_en;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

    // Lowercase keys are folded to uppercase. The Apple-1 character set has
    // no lowercase.
    assign key_in    = bus.kbd_data[6:0];
    assign key_upper = (key_in >= 7'h61 && key_in <= 7'h7A) ? key_in - 7'h20 : key_in;

    assign bus.kbd_ready = ~key_pending;
    assign capture       = bus.kbd_valid & ~key_pending;
    assign kbd_read      = bus_rd & (bus.address == 2'd0);

    // The sink pops on its own handshake, independent of the CPU enable.
    // A pop on the same edge frees a slot for a write into a full FIFO.
    assign pop    = ~fifo_empty & bus.dsp_ready;
    assign dsp_wr = bus_wr & (bus.address == 2'd2);
    assign push   = dsp_wr & (~fifo_full | pop);

    assign bus.dsp_valid = ~fifo_empty;
    assign bus.dsp_data  = mem[rd_ptr];

    // Keyboard side. A capture takes priority over a clearing KBD read on
    // the same edge so a fresh key is never silently lost.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            key_pending <= 1'b0;
            key_reg     <= '0;
        end else if (capture) begin
            key_pending <= 1'b1;
            key_reg     <= key_upper;
        end else if (kbd_read) begin
            key_pending <= 1'b0;
        end
    end

    // Control registers and the sticky overflow flag.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            kbdcr    <= '0;
            dspcr    <= '0;
            last_dsp <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus_wr && bus.address == 2'd1) begin
                kbdcr <= bus.din[6:0];
            end
            if (bus_wr && bus.address == 2'd3) begin
                dspcr    <= bus.din[5:0];
                overflow <= 1'b0;
            end
            if (dsp_wr) begin
                last_dsp <= bus.din[6:0];
                if (!push) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Display FIFO. Storage is reset so dsp_data reads zero out of reset.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.din[6:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // CPU read mux. It is a pure function of the registers and the address.
    always_comb begin
        bus.dout = 8'h00;
        case (bus.address)
            2'd0: bus.dout = {1'b1, key_reg};
            2'd1: bus.dout = {key_pending, kbdcr};
            2'd2: bus.dout = {fifo_full, last_dsp};
            2'd3: bus.dout = {1'b0, overflow, dspcr};
            default: bus.dout = 8'h00;
        endcase
    end
endmodule
